// File: rtl/rv_pkg.sv
// Shared core types: register/ROB index widths and the zero register.
package rv_pkg;

  localparam int ROB_WIDTH = 4;
  localparam int REG_WIDTH = 5;

  typedef logic [ROB_WIDTH-1:0] rob_id_t;
  typedef logic [REG_WIDTH-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational read port: x0 mask plus optional commit bypass.
// Bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_read_port
  import rv_pkg::*;
#(
  parameter int RW = ROB_WIDTH,
  parameter int GW = REG_WIDTH
) (
  input  logic [GW-1:0] idx,
  input  logic          entBusy,
  input  logic [RW-1:0] entTag,
  input  logic [31:0]   entVal,
  input  logic          cmtEn,
  input  logic [GW-1:0] cmtDest,
  input  logic [RW-1:0] cmtRobId,
  input  logic [31:0]   cmtValue,
  output logic          busy,
  output logic [RW-1:0] robId,
  output logic [31:0]   val
);

  logic zero;
  logic hit;

  assign zero = (idx == GW'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  assign hit = cmtEn && !zero && (idx == cmtDest)
             && entBusy && (entTag == cmtRobId);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    busy  = entBusy;
    robId = entTag;
    val   = entVal;
    if (hit) begin
      busy = 1'b0;
      val  = cmtValue;
    end
    if (zero) begin
      busy  = 1'b0;
      robId = '0;
      val   = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags (busy + producer ROB id).
// Optional same-cycle commit forwarding: REGFILE_BYPASS_EN.
module register_file
  import rv_pkg::*;
#(
  parameter int ROB_WIDTH = rv_pkg::ROB_WIDTH,
  parameter int REG_WIDTH = rv_pkg::REG_WIDTH
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 clear,
  input  logic                 issueFlag,
  input  logic [REG_WIDTH-1:0] issueDest,
  input  logic [ROB_WIDTH-1:0] issueRobId,
  input  logic                 commitFlag,
  input  logic [ROB_WIDTH-1:0] commitRobId,
  input  logic [REG_WIDTH-1:0] commitDest,
  input  logic [31:0]          commitValue,
  input  logic [REG_WIDTH-1:0] rs1Idx,
  input  logic [REG_WIDTH-1:0] rs2Idx,
  output logic                 rs1Busy,
  output logic [ROB_WIDTH-1:0] rs1RobId,
  output logic [31:0]          rs1Val,
  output logic                 rs2Busy,
  output logic [ROB_WIDTH-1:0] rs2RobId,
  output logic [31:0]          rs2Val
);

  localparam int NREG = 2 ** REG_WIDTH;
  localparam logic [REG_WIDTH-1:0] ZR = REG_WIDTH'(REG_ZERO);

  logic [31:0]          vals [NREG];
  logic [ROB_WIDTH-1:0] tags [NREG];
  logic [NREG-1:0]      busy;

  logic cmtWr;
  logic issWr;

  assign cmtWr = readyIn && commitFlag && (commitDest != ZR);
  assign issWr = readyIn && issueFlag && (issueDest != ZR) && !clear;

  // Issue follows commit so a same-register issue keeps busy and its new tag.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        vals[i] <= '0;
        tags[i] <= '0;
      end
    end else begin
      if (cmtWr) begin
        vals[commitDest] <= commitValue;
        if (busy[commitDest] && tags[commitDest] == commitRobId)
          busy[commitDest] <= 1'b0;
      end
      if (readyIn && clear)
        busy <= '0;
      else if (issWr) begin
        busy[issueDest] <= 1'b1;
        tags[issueDest] <= issueRobId;
      end
    end
  end

  regfile_read_port #(.RW(ROB_WIDTH), .GW(REG_WIDTH)) u_rs1 (
    .idx      (rs1Idx),
    .entBusy  (busy[rs1Idx]),
    .entTag   (tags[rs1Idx]),
    .entVal   (vals[rs1Idx]),
    .cmtEn    (cmtWr),
    .cmtDest  (commitDest),
    .cmtRobId (commitRobId),
    .cmtValue (commitValue),
    .busy     (rs1Busy),
    .robId    (rs1RobId),
    .val      (rs1Val)
  );

  regfile_read_port #(.RW(ROB_WIDTH), .GW(REG_WIDTH)) u_rs2 (
    .idx      (rs2Idx),
    .entBusy  (busy[rs2Idx]),
    .entTag   (tags[rs2Idx]),
    .entVal   (vals[rs2Idx]),
    .cmtEn    (cmtWr),
    .cmtDest  (commitDest),
    .cmtRobId (commitRobId),
    .cmtValue (commitValue),
    .busy     (rs2Busy),
    .robId    (rs2RobId),
    .val      (rs2Val)
  );

endmodule
